// File: rtl/ecg_beat_detector.sv
// R-peak detector for the ECG sample stream: threshold crossing with refractory
// lockout, beat interval measurement, beat counting and loss-of-signal flag.
module ecg_beat_detector #(
    parameter logic [15:0] THRESHOLD  = 16'h9000,
    parameter int unsigned REFRACTORY = 40,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [15:0] sample_in,
    input  logic        enable,
    output logic        beat,
    output logic [15:0] peak_value,
    output logic [15:0] interval,
    output logic        interval_valid,
    output logic [7:0]  beat_count,
    output logic        lost
);

    localparam logic [15:0] REF_LOAD = 16'(REFRACTORY - 1);
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        ARMED,
        ABOVE,
        REFRACT
    } state_t;

    state_t      state;
    logic [15:0] peak_track;
    logic [15:0] ref_cnt;
    logic [15:0] since_cnt;
    logic        have_prev;

    logic        above;
    logic [15:0] since_next;
    logic        timeout_hit;

    assign above       = (sample_in >= THRESHOLD);
    assign since_next  = (since_cnt == 16'hFFFF) ? since_cnt : since_cnt + 16'd1;
    assign timeout_hit = (since_next == TIMEOUT_W);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ARMED;
            peak_track     <= '0;
            ref_cnt        <= '0;
            since_cnt      <= '0;
            have_prev      <= 1'b0;
            beat           <= 1'b0;
            peak_value     <= '0;
            interval       <= '0;
            interval_valid <= 1'b0;
            beat_count     <= '0;
            lost           <= 1'b0;
        end else begin
            beat <= 1'b0;
            if (!enable) begin
                state          <= ARMED;
                ref_cnt        <= '0;
                since_cnt      <= '0;
                have_prev      <= 1'b0;
                interval_valid <= 1'b0;
            end else if (sample_valid) begin
                since_cnt <= since_next;
                if (timeout_hit) begin
                    lost <= 1'b1;
                end
                unique case (state)
                    ARMED: begin
                        if (above) begin
                            state      <= ABOVE;
                            peak_track <= sample_in;
                        end
                    end
                    ABOVE: begin
                        if (above) begin
                            if (sample_in > peak_track) begin
                                peak_track <= sample_in;
                            end
                        end else begin
                            // Beat: later assignments override the timeout set above.
                            beat       <= 1'b1;
                            peak_value <= peak_track;
                            ref_cnt    <= REF_LOAD;
                            state      <= REFRACT;
                            since_cnt  <= '0;
                            beat_count <= beat_count + 8'd1;
                            lost       <= 1'b0;
                            have_prev  <= 1'b1;
                            if (have_prev) begin
                                interval       <= since_next;
                                interval_valid <= 1'b1;
                            end
                        end
                    end
                    REFRACT: begin
                        if (ref_cnt != 16'd0) begin
                            ref_cnt <= ref_cnt - 16'd1;
                        end else if (!above) begin
                            state <= ARMED;
                        end
                    end
                    default: begin
                        state <= ARMED;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ecg_beat_detector.sv
// Scoreboard bench for ecg_beat_detector: expected beats are queued as stimulus
// is driven and checked by a monitor when the beat pulse appears.
`timescale 1ns/1ps
module tb_ecg_beat_detector;

    logic        clk;
    logic        reset;
    logic        sample_valid;
    logic [15:0] sample_in;
    logic        enable;
    logic        beat;
    logic [15:0] peak_value;
    logic [15:0] interval;
    logic        interval_valid;
    logic [7:0]  beat_count;
    logic        lost;

    typedef struct packed {
        logic [15:0] peak;
        logic [15:0] ival;
        logic        iv;
        logic [7:0]  cnt;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp;
    int         n_bad;
    logic [7:0] exp_count;
    logic       prev_beat;

    ecg_beat_detector dut (
        .clk            (clk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .sample_in      (sample_in),
        .enable         (enable),
        .beat           (beat),
        .peak_value     (peak_value),
        .interval       (interval),
        .interval_valid (interval_valid),
        .beat_count     (beat_count),
        .lost           (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    always @(negedge clk) begin
        exp_t e;
        if (beat) begin
            n_cmp++;
            if (prev_beat) begin
                n_bad++;
                $display("FAIL beat_width: beat high 2 cycles, required 1");
            end
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_beat: got beat count=%0d, required none",
                         beat_count);
            end else begin
                e = sb.pop_front();
                if ({peak_value, interval, interval_valid, beat_count} !==
                    {e.peak, e.ival, e.iv, e.cnt}) begin
                    n_bad++;
                    $display("FAIL beat_fields: got peak=%h ival=%0d iv=%b cnt=%0d, required peak=%h ival=%0d iv=%b cnt=%0d",
                             peak_value, interval, interval_valid, beat_count,
                             e.peak, e.ival, e.iv, e.cnt);
                end
            end
        end
        prev_beat = beat;
    end

    function automatic logic [15:0] tmpl(input int i);
        logic [15:0] v;
        v = 16'h0000;
        if (i >= 10 && i < 20) v = 16'h1800;
        if (i >= 60 && i < 80) v = 16'h2000;
        case (i)
            30: v = 16'h6000;
            31: v = 16'h8000;
            32: v = 16'h9000;
            33: v = 16'hA000;
            34: v = 16'hC000;
            35: v = 16'hE000;
            36: v = 16'hC000;
            37: v = 16'hA000;
            38: v = 16'h8000;
            39: v = 16'h6000;
            40: v = 16'h4000;
            41: v = 16'h3000;
            42: v = 16'h2000;
            43: v = 16'h1000;
            default: ;
        endcase
        return v;
    endfunction

    task automatic put(input logic [15:0] v, input int idle);
        sample_valid = 1'b1;
        sample_in    = v;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        sample_in    = '0;
        repeat (idle) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_beat(input logic [15:0] pk, input logic [15:0] iv_val,
                               input logic iv);
        exp_t e;
        exp_count = exp_count + 8'd1;
        e.peak = pk;
        e.ival = iv_val;
        e.iv   = iv;
        e.cnt  = exp_count;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_count = '0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        enable       = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({beat, peak_value, interval, interval_valid, beat_count, lost} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got beat=%b pk=%h ival=%h iv=%b cnt=%0d lost=%b, required all 0",
                     beat, peak_value, interval, interval_valid, beat_count, lost);
        end
        reset = 1'b0;
        exp_count = '0;
    endtask

    task automatic test_template();
        do_reset();
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 100; i++) begin
                if (i == 38) begin
                    if (p == 0) expect_beat(16'hE000, 16'd0, 1'b0);
                    else        expect_beat(16'hE000, 16'd100, 1'b1);
                end
                put(tmpl(i), 3);
            end
            n_cmp++;
            if (lost !== 1'b0 || beat_count !== 8'(p + 1)) begin
                n_bad++;
                $display("FAIL template_period: got lost=%b cnt=%0d, required lost=0 cnt=%0d",
                         lost, beat_count, p + 1);
            end
        end
        n_cmp++;
        if (sb.size() != 0 || interval !== 16'd100 || interval_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL template_end: got pending=%0d ival=%0d iv=%b, required 0 100 1",
                     sb.size(), interval, interval_valid);
        end
    endtask

    task automatic test_double_peak();
        do_reset();
        expect_beat(16'hA000, 16'd0, 1'b0);
        put(16'hA000, 0);
        put(16'h0000, 0);
        for (int k = 1; k <= 43; k++) begin
            put((k >= 10 && k <= 12) ? 16'hA000 : 16'h0000, 0);
        end
        n_cmp++;
        if (beat_count !== 8'd1) begin
            n_bad++;
            $display("FAIL double_peak_locked: got cnt=%0d, required 1", beat_count);
        end
        put(16'hA000, 0);
        expect_beat(16'hA000, 16'd45, 1'b1);
        put(16'h0000, 2);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL double_peak_missing: got %0d pending beats, required 0", sb.size());
        end
    endtask

    task automatic test_held_above();
        do_reset();
        expect_beat(16'hA000, 16'd0, 1'b0);
        put(16'hA000, 0);
        put(16'h0000, 0);
        for (int k = 1; k <= 100; k++) put(16'hA000, 0);
        n_cmp++;
        if (beat_count !== 8'd1) begin
            n_bad++;
            $display("FAIL held_above_retrigger: got cnt=%0d, required 1", beat_count);
        end
        put(16'h0000, 0);
        put(16'hB000, 0);
        expect_beat(16'hB000, 16'd103, 1'b1);
        put(16'h0000, 2);
        n_cmp++;
        if (sb.size() != 0 || beat_count !== 8'd2) begin
            n_bad++;
            $display("FAIL held_above_rearm: got pending=%0d cnt=%0d, required 0 2",
                     sb.size(), beat_count);
        end
    endtask

    task automatic test_lost();
        do_reset();
        for (int k = 1; k <= 998; k++) put(16'h0000, 0);
        put(16'hA000, 0);
        expect_beat(16'hA000, 16'd0, 1'b0);
        put(16'h0000, 0);
        n_cmp++;
        if (lost !== 1'b0) begin
            n_bad++;
            $display("FAIL lost_beat_wins: got lost=%b, required 0", lost);
        end
        for (int k = 1; k <= 999; k++) put(16'h0000, 0);
        n_cmp++;
        if (lost !== 1'b0) begin
            n_bad++;
            $display("FAIL lost_early: got lost=%b after 999, required 0", lost);
        end
        put(16'h0000, 0);
        n_cmp++;
        if (lost !== 1'b1) begin
            n_bad++;
            $display("FAIL lost_rise: got lost=%b after 1000, required 1", lost);
        end
        put(16'hA000, 0);
        expect_beat(16'hA000, 16'd1002, 1'b1);
        put(16'h0000, 0);
        n_cmp++;
        if (lost !== 1'b0) begin
            n_bad++;
            $display("FAIL lost_clear: got lost=%b after beat, required 0", lost);
        end
        for (int k = 1; k <= 70000; k++) put(16'h0000, 0);
        n_cmp++;
        if (lost !== 1'b1) begin
            n_bad++;
            $display("FAIL lost_quiet: got lost=%b, required 1", lost);
        end
        put(16'hC000, 0);
        expect_beat(16'hC000, 16'hFFFF, 1'b1);
        put(16'h0000, 2);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL lost_missing: got %0d pending beats, required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_above();
        do_reset();
        expect_beat(16'hA000, 16'd0, 1'b0);
        put(16'hA000, 0);
        put(16'h0000, 0);
        for (int k = 1; k <= 40; k++) put(16'h0000, 0);
        put(16'hA000, 0);
        put(16'hE000, 1);
        reset = 1'b1;
        #2;
        n_cmp++;
        if ({beat, peak_value, interval, interval_valid, beat_count, lost} !== '0) begin
            n_bad++;
            $display("FAIL reset_async: got pk=%h cnt=%0d iv=%b lost=%b, required all 0",
                     peak_value, beat_count, interval_valid, lost);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_count = '0;
        for (int i = 0; i < 100; i++) begin
            if (i == 38) expect_beat(16'hE000, 16'd0, 1'b0);
            put(tmpl(i), 3);
        end
        n_cmp++;
        if (sb.size() != 0 || interval_valid !== 1'b0 || beat_count !== 8'd1) begin
            n_bad++;
            $display("FAIL reset_restart: got pending=%0d iv=%b cnt=%0d, required 0 0 1",
                     sb.size(), interval_valid, beat_count);
        end
    endtask

    task automatic test_enable();
        do_reset();
        expect_beat(16'hA000, 16'd0, 1'b0);
        put(16'hA000, 0);
        put(16'h0000, 0);
        for (int k = 1; k <= 44; k++) put(16'h0000, 0);
        put(16'hA000, 0);
        expect_beat(16'hA000, 16'd46, 1'b1);
        put(16'h0000, 0);
        enable = 1'b0;
        for (int k = 0; k < 20; k++) put((k % 2 == 0) ? 16'hA000 : 16'h0000, 0);
        n_cmp++;
        if (beat_count !== 8'd2 || interval_valid !== 1'b0 || interval !== 16'd46) begin
            n_bad++;
            $display("FAIL enable_hold: got cnt=%0d iv=%b ival=%0d, required 2 0 46",
                     beat_count, interval_valid, interval);
        end
        enable = 1'b1;
        for (int k = 0; k < 5; k++) put(16'h0000, 0);
        put(16'hA000, 0);
        expect_beat(16'hA000, 16'd46, 1'b0);
        put(16'h0000, 0);
        for (int k = 1; k <= 49; k++) put(16'h0000, 0);
        put(16'hA000, 0);
        expect_beat(16'hA000, 16'd51, 1'b1);
        put(16'h0000, 2);
        n_cmp++;
        if (sb.size() != 0 || beat_count !== 8'd4) begin
            n_bad++;
            $display("FAIL enable_resume: got pending=%0d cnt=%0d, required 0 4",
                     sb.size(), beat_count);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        exp_count = '0;
        prev_beat = 1'b0;
        test_reset();
        test_template();
        test_double_peak();
        test_held_above();
        test_lost();
        test_reset_mid_above();
        test_enable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ecg_beat_detector.md
# ecg_beat_detector

Downstream consumer of the ECG sample stream produced by the ECG wave source: it watches each 16-bit sample as it is issued and detects R-peaks by threshold crossing with a refractory lockout. It reports a one-cycle beat pulse, the captured peak amplitude, the beat-to-beat interval in samples, a wrapping beat count and a sticky loss-of-signal flag. It sits between the sample source and the display or heart-rate logic, sharing its clock domain.

## Interface

- THRESHOLD, 16'h9000: detection level; a sample is "above" when sample_in >= THRESHOLD (unsigned compare).
- REFRACTORY, 40: number of valid samples ignored after a beat before re-arming (1..65535).
- TIMEOUT, 1000: number of valid samples without a beat before lost asserts (1..65535).
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- sample_valid  input  1  qualifies sample_in for exactly this cycle (driven from sample_req timing).
- sample_in  input  16  sample value, treated as unsigned.
- enable  input  1  detection enable; low forces the idle/armed condition.
- beat  output  1  one-cycle pulse per detected beat.
- peak_value  output  16  maximum sample seen during the last detected beat.
- interval  output  16  valid samples between the last two beats, saturating at 16'hFFFF.
- interval_valid  output  1  high once two beats have been detected since reset or enable; stays high until then cleared.
- beat_count  output  8  number of beats detected, wraps 255→0.
- lost  output  1  sticky; set when no beat occurs for TIMEOUT samples, cleared by the next beat.

## Operation

- All state advances only on cycles with sample_valid=1, except reset and enable.
- FSM states:
  - ARMED: above sample → ABOVE, peak_track <= sample. Below sample → stay.
  - ABOVE: above sample → peak_track <= max(peak_track, sample). Below sample → beat fires, peak_value <= peak_track, ref_cnt <= REFRACTORY-1 → REFRACT.
  - REFRACT: ref_cnt != 0 → decrement. ref_cnt == 0 and below sample → ARMED. ref_cnt == 0 and above sample → stay; no retrigger until the signal drops below THRESHOLD.
- since_cnt counts valid samples since the last beat, saturating at 16'hFFFF. It increments on every valid sample in every state.
- On the beat sample:
  - interval <= sat(since_cnt+1) if a previous beat exists; otherwise interval is unchanged. interval_valid <= 1 when a previous beat exists.
  - since_cnt <= 0, beat_count <= beat_count+1, lost <= 0, have_prev <= 1.
- lost <= 1 on the valid sample at which since_cnt+1 reaches TIMEOUT. Before the first beat, the count runs from reset or enable rise.
- enable=0: FSM goes to ARMED, since_cnt <= 0, have_prev <= 0, interval_valid <= 0, beat held 0. peak_value, interval, beat_count and lost hold their values.
- A beat and a timeout on the same sample: the beat wins and lost is 0.

## Timing

- Reset values: beat=0, peak_value=0, interval=0, interval_valid=0, beat_count=0, lost=0, FSM=ARMED, counters=0.
- Latency: beat, peak_value, interval, interval_valid and beat_count all update on the clock edge that samples the qualifying sample_valid. They are visible in the following cycle.
- beat is high for exactly one clk cycle regardless of sample rate.
- Reset asserted mid-ABOVE or mid-REFRACT returns to the reset values immediately, with no beat pulse.
- Back-to-back sample_valid on consecutive cycles must be supported.

## Test plan

- Periodic 100-sample ECG template (baseline 0, P-wave ≤16'h2000, QRS ramp 16'h6000→16'hE000→16'h1000 at indices 30–43, T-wave ≤16'h2000), one sample per 4 cycles, repeated 5 times. Required response: first beat on index 38 (16'h8000 is the first sample below threshold) with peak_value=16'hE000. interval_valid rises at the second beat with interval=100. beat_count=5. lost=0 throughout.
- Double peak: second crossing of 16'hA000 ten samples after a beat, REFRACTORY=40. Required response: no second beat. A crossing 45 samples after the beat, preceded by a below-threshold sample, produces a beat with interval=45.
- Signal held above THRESHOLD for 100 samples after a beat. Required response: no retrigger. The next beat occurs only after a below sample followed by a fresh crossing.
- Flat-zero input for 1000 samples after a beat, TIMEOUT=1000. Required response: lost rises on the 1000th sample and clears on the next beat. After 70000 quiet samples, the next beat reports interval=16'hFFFF.
- Reset asserted while in ABOVE (sample 16'hE000 pending). Required response: outputs zero at once. The subsequent template gives a first beat with interval_valid=0.
- enable dropped for 20 samples between beats. Required response: no beats during that window. After re-enable, the first beat leaves interval_valid=0 and the second beat reports a correct interval.
